multicycle_ctrl: RTL

Sequencing controller that turns the single-cycle core datapath into a multicycle machine sharing one unified instruction/data memory port. A Moore FSM steps each RV32 subset instruction (lw, sw, R-type, I-type ALU, beq/bne, jal, lui) through fetch, decode, execute, memory and writeback. It drives all datapath enables and mux selects, stalls on a memory ready handshake, traps on illegal opcodes, and counts retired instructions.

---
 rtl/riscv_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 26 ++
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32 subset core: opcodes, controller
// states and the datapath select/control encodings used by both controller and datapath.
package riscv_pkg;

    // Major opcodes of the supported instruction subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Controller states
    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        JAL,
        LUI,
        TRAP
    } state_t;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format encodings
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result mux encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operand A mux encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B mux encodings
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // A store is the only memory opcode that needs the S-format immediate
    function automatic logic is_store(input logic [6:0] op);
        return op == OP_STORE;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 of an R- or I-type ALU instruction to an ALU operation
// and flags encodings the core does not implement.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       legal
);

    // Subtract exists only as an R-type; addi with bit 30 set is still an add
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style sequencing controller for the multicycle RV32 subset core sharing
// one instruction/data memory port; also keeps the trap flag and retire counter.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;
    logic        retire;
    logic [2:0]  dec_alu_control;
    logic        dec_legal;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_rtype    (state_q == EXEC_R),
        .alu_control (dec_alu_control),
        .legal       (dec_legal)
    );

    // Per-state strobes/selects and next state; reset blanks every output combinationally
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        illegal    = illegal_q;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = is_store(opcode) ? IMM_S : IMM_I;
                state_d = is_store(opcode) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R, EXEC_I: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = (state_q == EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = dec_alu_control;
                state_d    = dec_legal ? ALUWB : TRAP;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                if (funct3[2:1] == 2'b00) begin
                    PCWrite = zero ^ funct3[0];
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = TRAP;
                end
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
        if (rst) begin
            state_d    = FETCH;
            retire     = 1'b0;
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_RS2;
            ResultSrc  = RES_ALUOUT;
            ImmSrc     = IMM_I;
            ALUControl = ALU_ADD;
            illegal    = 1'b0;
        end
    end

    // Retire counter wraps naturally; the trap flag sets on entry to TRAP and sticks
    always_comb begin
        instret_d = instret_q + {31'd0, retire};
        illegal_d = illegal_q | (state_d == TRAP);
    end

    assign instret = instret_q;

    // State, retire count and trap flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
